// File: rtl/pix_dispatch_pkg.sv
// Shared types and helpers for the pix_dispatch frame dispatcher.
package pix_dispatch_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StDispatch = 2'b01,
        StDrain    = 2'b10,
        StDone     = 2'b11
    } state_e;

    // Outstanding-pixel counter width: room for up to two pixels in flight per core.
    function automatic int unsigned out_cnt_width(input int unsigned num_cores);
        return $clog2(num_cores * 2 + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index above the last grant, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] ptr
);
    localparam int unsigned PtrW = $clog2(N);

    logic [PtrW-1:0] sel;
    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        sel   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = PtrW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                sel        = idx;
                found      = 1'b1;
            end
        end
    end

    // Pointer parks on the last granted core; reset value makes core 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PtrW'(N - 1);
        end else if (advance && found) begin
            ptr <= sel;
        end
    end

endmodule

// File: rtl/pix_dispatch.sv
// Raster-order pixel dispatcher feeding a core array over a round-robin req/grant handshake.
// Optional PIX_DISPATCH_STATS_EN adds a frame_cycles busy-cycle counter output.
module pix_dispatch
    import pix_dispatch_pkg::*;
#(
    parameter int unsigned NUM_X_BITS = 4,
    parameter int unsigned NUM_Y_BITS = 4,
    parameter int unsigned NUM_CORES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_X_BITS-1:0] x_max,
    input  logic [NUM_Y_BITS-1:0] y_max,
    input  logic [NUM_CORES-1:0]  core_req,
    input  logic [NUM_CORES-1:0]  core_done,
    output logic                  disp_valid,
    output logic [NUM_CORES-1:0]  disp_grant,
    output logic [NUM_X_BITS-1:0] disp_x,
    output logic [NUM_Y_BITS-1:0] disp_y,
    output logic                  busy,
    output logic                  frame_done
`ifdef PIX_DISPATCH_STATS_EN
    ,
    output logic [31:0]           frame_cycles
`endif
);
    localparam int unsigned CntW  = out_cnt_width(NUM_CORES);
    localparam int unsigned CntW1 = CntW + 1;
    localparam int unsigned PtrW  = $clog2(NUM_CORES);

    state_e                state_q;
    logic [NUM_X_BITS-1:0] x_q;
    logic [NUM_X_BITS-1:0] x_max_q;
    logic [NUM_Y_BITS-1:0] y_q;
    logic [NUM_Y_BITS-1:0] y_max_q;
    logic [CntW-1:0]       out_cnt;
    logic [CntW-1:0]       out_next;
    logic [CntW1-1:0]      done_cnt;
    logic [CntW1-1:0]      cnt_up;
    logic [NUM_CORES-1:0]  last_mask;
    logic [NUM_CORES-1:0]  eligible;
    logic [NUM_CORES-1:0]  arb_grant;
    logic [PtrW-1:0]       arb_ptr;
    logic                  issue;

    // The arbiter pointer names the core granted last cycle, so it doubles as the
    // one-cycle mask that stops a still-held request from being granted twice.
    assign last_mask = disp_valid ? (NUM_CORES'(1) << arb_ptr) : '0;
    assign eligible  = core_req & ~last_mask;
    assign issue     = (state_q == StDispatch) && (|eligible) && !abort;
    assign busy      = (state_q == StDispatch) || (state_q == StDrain);

    rr_arbiter #(
        .N(NUM_CORES)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (eligible),
        .advance(issue),
        .grant  (arb_grant),
        .ptr    (arb_ptr)
    );

    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_cnt = done_cnt + CntW1'(core_done[i]);
        end
        cnt_up   = {1'b0, out_cnt} + CntW1'(issue);
        out_next = (cnt_up > done_cnt) ? CntW'(cnt_up - done_cnt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            x_max_q    <= '0;
            y_max_q    <= '0;
            out_cnt    <= '0;
            disp_valid <= 1'b0;
            disp_grant <= '0;
            disp_x     <= '0;
            disp_y     <= '0;
            frame_done <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            disp_grant <= '0;
            frame_done <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                out_cnt <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            x_max_q <= x_max;
                            y_max_q <= y_max;
                            x_q     <= '0;
                            y_q     <= '0;
                            out_cnt <= '0;
                            state_q <= StDispatch;
                        end
                    end
                    StDispatch: begin
                        out_cnt <= out_next;
                        if (issue) begin
                            disp_valid <= 1'b1;
                            disp_grant <= arb_grant;
                            disp_x     <= x_q;
                            disp_y     <= y_q;
                            if (x_q == x_max_q) begin
                                x_q <= '0;
                                if (y_q == y_max_q) begin
                                    state_q <= StDrain;
                                end else begin
                                    y_q <= y_q + NUM_Y_BITS'(1);
                                end
                            end else begin
                                x_q <= x_q + NUM_X_BITS'(1);
                            end
                        end
                    end
                    StDrain: begin
                        out_cnt <= out_next;
                        if (out_cnt == '0) begin
                            state_q    <= StDone;
                            frame_done <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef PIX_DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cycles <= '0;
        end else if (state_q == StIdle && start && !abort) begin
            frame_cycles <= '0;
        end else if (busy) begin
            frame_cycles <= frame_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pix_dispatch.sv
// Self-checking bench for pix_dispatch: table-driven frames with a coordinate scoreboard,
// plus hand-written reset, net-count and abort sequences.
module tb_pix_dispatch;
    import pix_dispatch_pkg::*;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  x_max;
    logic [3:0]  y_max;
    logic [3:0]  core_req;
    logic [3:0]  core_done;
    logic        disp_valid;
    logic [3:0]  disp_grant;
    logic [3:0]  disp_x;
    logic [3:0]  disp_y;
    logic        busy;
    logic        frame_done;
`ifdef PIX_DISPATCH_STATS_EN
    logic [31:0] frame_cycles;
`endif

    pix_dispatch #(
        .NUM_X_BITS(4),
        .NUM_Y_BITS(4),
        .NUM_CORES (NC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .x_max     (x_max),
        .y_max     (y_max),
        .core_req  (core_req),
        .core_done (core_done),
        .disp_valid(disp_valid),
        .disp_grant(disp_grant),
        .disp_x    (disp_x),
        .disp_y    (disp_y),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef PIX_DISPATCH_STATS_EN
        ,
        .frame_cycles(frame_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int tb_ptr = NC - 1;

    typedef struct {
        int x;
        int y;
        int core;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int       xm;
        int       ym;
        bit [3:0] mask;
        bit       hold;
        int       delay;
        bit       chk_core;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int next_in_mask(input int p, input bit [3:0] m);
        for (int i = 1; i <= NC; i++) begin
            int k;
            k = (p + i) % NC;
            if (m[k[1:0]]) return k;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        int idx;
        int n;
        idx = -1;
        n = 0;
        for (int i = 0; i < NC; i++) begin
            if (g[i]) begin
                idx = i;
                n++;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        core_req = '0;
        core_done = '0;
        @(negedge clk);
        rst = 1'b0;
        tb_ptr = NC - 1;
    endtask

    // Runs one frame with a simple core model; coordinates come from the scoreboard.
    task automatic run_frame(input vec_t v, input string tag);
        logic [3:0] done_sched [0:511];
        bit         core_busy  [NC];
        int         cyc, grants, dones_drv, last_done, fd_cyc, prev_gi, gi, busy_cycles;
        bit         cnt_bad, in_mask;
        exp_t       e;
        for (int i = 0; i < 512; i++) done_sched[i] = '0;
        for (int c = 0; c < NC; c++) core_busy[c] = 1'b0;
        sb.delete();
        for (int y = 0; y <= v.ym; y++) begin
            for (int x = 0; x <= v.xm; x++) begin
                e.x = x;
                e.y = y;
                e.core = -1;
                if (v.chk_core) begin
                    e.core = next_in_mask(tb_ptr, v.mask);
                    tb_ptr = e.core;
                end
                sb.push_back(e);
            end
        end
        cyc = 0; grants = 0; dones_drv = 0; last_done = -100; fd_cyc = -1; prev_gi = -1;
        cnt_bad = 1'b0;
        @(negedge clk);
        x_max = 4'(v.xm);
        y_max = 4'(v.ym);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = int'(busy);
        core_req = v.mask;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            busy_cycles += int'(busy);
            if (disp_valid) begin
                gi = onehot_idx(disp_grant);
                check({tag, "_grant_onehot"}, int'(gi >= 0), 1);
                if (sb.size() == 0) begin
                    check({tag, "_sb_underflow"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_x"}, int'(disp_x), e.x);
                    check({tag, "_y"}, int'(disp_y), e.y);
                    if (e.core >= 0) check({tag, "_core"}, gi, e.core);
                end
                in_mask = (gi >= 0) ? v.mask[gi[1:0]] : 1'b0;
                check({tag, "_grant_in_mask"}, int'(in_mask), 1);
                check({tag, "_double_grant"}, int'(gi >= 0 && gi == prev_gi), 0);
                grants++;
                if (gi >= 0) begin
                    core_busy[gi] = 1'b1;
                    if (cyc + v.delay < 512) done_sched[cyc + v.delay][gi[1:0]] = 1'b1;
                end
                prev_gi = gi;
            end else begin
                prev_gi = -1;
            end
            if (int'(dut.out_cnt) != grants - dones_drv) cnt_bad = 1'b1;
            if (frame_done) begin
                fd_cyc = cyc;
                break;
            end
            core_done = done_sched[cyc];
            for (int c = 0; c < NC; c++) begin
                if (core_done[c]) begin
                    dones_drv++;
                    core_busy[c] = 1'b0;
                    last_done = cyc;
                end
            end
            for (int c = 0; c < NC; c++) core_req[c] = v.mask[c] && (v.hold || !core_busy[c]);
        end
        core_req = '0;
        core_done = '0;
        check({tag, "_frame_done_seen"}, int'(fd_cyc >= 0), 1);
        check({tag, "_done_latency"}, fd_cyc - last_done, 2);
        check({tag, "_grant_count"}, grants, (v.xm + 1) * (v.ym + 1));
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_outstanding_track"}, int'(cnt_bad), 0);
`ifdef PIX_DISPATCH_STATS_EN
        check({tag, "_frame_cycles"}, int'(frame_cycles), busy_cycles);
`endif
        @(negedge clk);
        check({tag, "_frame_done_pulse"}, int'(frame_done), 0);
        check({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        bit bad;
        vecs[0] = '{xm: 3, ym: 2, mask: 4'hF, hold: 1'b1, delay: 2, chk_core: 1'b1};
        vecs[1] = '{xm: 0, ym: 0, mask: 4'h2, hold: 1'b0, delay: 3, chk_core: 1'b1};
        vecs[2] = '{xm: 2, ym: 1, mask: 4'h1, hold: 1'b0, delay: 3, chk_core: 1'b1};
        vecs[3] = '{xm: 3, ym: 3, mask: 4'hA, hold: 1'b0, delay: 1, chk_core: 1'b0};
        vecs[4] = '{xm: 1, ym: 0, mask: 4'h5, hold: 1'b1, delay: 4, chk_core: 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        x_max = '0; y_max = '0; core_req = '0; core_done = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", int'(disp_valid), 0);
        check("rst_grant", int'(disp_grant), 0);
        check("rst_xy", int'({disp_x, disp_y}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_state", int'(dut.state_q), int'(StIdle));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a frame, then a clean restart.
        @(negedge clk);
        x_max = 4'd3; y_max = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; core_req = 4'hF;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (disp_valid && disp_x == 4'd2 && disp_y == 4'd1) found = 1'b1;
        end
        check("midrst_reached_2_1", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", int'(disp_valid), 0);
        check("midrst_grant", int'(disp_grant), 0);
        check("midrst_xy", int'({disp_x, disp_y}), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_state", int'(dut.state_q), int'(StIdle));
        @(negedge clk);
        rst = 1'b0; core_req = '0; tb_ptr = NC - 1;
        run_frame('{xm: 1, ym: 1, mask: 4'hF, hold: 1'b1, delay: 1, chk_core: 1'b1}, "restart");

        // Cores 1 and 3 retire on the same edge that core 0 is granted.
        do_reset();
        x_max = 4'd3; y_max = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; core_req = 4'b1010;
        @(negedge clk);
        check("net_grant_a", int'(disp_grant), 4'b0010);
        check("net_x_a", int'(disp_x), 0);
        @(negedge clk);
        check("net_grant_b", int'(disp_grant), 4'b1000);
        check("net_x_b", int'(disp_x), 1);
        check("net_cnt_before", int'(dut.out_cnt), 2);
        core_req = 4'b0001; core_done = 4'b1010;
        @(negedge clk);
        core_req = '0; core_done = '0;
        check("net_grant_c", int'(disp_grant), 4'b0001);
        check("net_x_c", int'(disp_x), 2);
        check("net_cnt_after", int'(dut.out_cnt), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Abort with three pixels outstanding; late retirements must be ignored.
        x_max = 4'd3; y_max = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; core_req = 4'hF;
        repeat (3) @(negedge clk);
        core_req = '0;
        @(negedge clk);
        check("abort_cnt_before", int'(dut.out_cnt), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_state", int'(dut.state_q), int'(StIdle));
        check("abort_cnt", int'(dut.out_cnt), 0);
        core_done = 4'b0111;
        @(negedge clk);
        core_done = '0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (frame_done || disp_valid || busy || dut.out_cnt != '0) bad = 1'b1;
        end
        check("abort_quiet", int'(bad), 0);

        // start and abort together: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pix_dispatch.md
# pix_dispatch

Frame-level work dispatcher for the Julia renderer. It scans pixel coordinates raster-order (x fastest) from (0,0) to (x_max,y_max) and hands one coordinate at a time to NUM_CORES compute cores through a round-robin req/grant handshake. It counts how many pixels are outstanding in the cores and signals frame completion once every pixel is issued and retired. It sits between the host/control registers and the core array.

## Interface
- NUM_X_BITS, 4, width of x coordinate
- NUM_Y_BITS, 4, width of y coordinate
- NUM_CORES, 4, number of requesting cores (2..16)
- clk  in  1  system clock; one clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  pulse; begins a frame when in IDLE, otherwise ignored
- abort  in  1  pulse; synchronous return to IDLE from any state
- x_max  in  NUM_X_BITS  last x column, sampled on accepted start
- y_max  in  NUM_Y_BITS  last y row, sampled on accepted start
- core_req  in  NUM_CORES  per-core work request, level, held until granted
- core_done  in  NUM_CORES  per-core one-cycle pulse, pixel retired
- disp_valid  out  1  grant valid this cycle
- disp_grant  out  NUM_CORES  one-hot granted core, zero when disp_valid=0
- disp_x  out  NUM_X_BITS  pixel x for granted core
- disp_y  out  NUM_Y_BITS  pixel y for granted core
- busy  out  1  high in DISPATCH or DRAIN
- frame_done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE (encoding from package).
- IDLE: start=1 -> latch x_max/y_max, x=y=0, outstanding=0, go DISPATCH.
- DISPATCH: if any eligible req, round-robin arbiter picks lowest index above last-granted (wrapping); registers disp_valid=1, disp_grant, disp_x/disp_y = current (x,y); then advance x; x==x_max -> x=0, y+1. Issuing (x_max,y_max) -> DRAIN.
- Eligible req = core_req AND NOT disp_grant-of-current-cycle (granted core masked one cycle so a held req is never double-granted); core must drop req the cycle after seeing its grant.
- Outstanding counter, width $clog2(NUM_CORES*2+1): +1 per grant, -1 per core_done bit set; multiple core_done bits same cycle subtract popcount; grant and done same cycle net out.
- core_done with outstanding=0: ignored, counter saturates at 0.
- DRAIN: no grants; outstanding==0 -> DONE.
- DONE: frame_done=1 for one cycle, -> IDLE.
- x_max=0,y_max=0: single-pixel frame, one grant, then DRAIN.
- abort: any state -> IDLE next cycle, outstanding cleared, no frame_done; later core_done pulses ignored.
- start while not IDLE: ignored. start and abort together: abort wins.

## Timing
- Reset values: state IDLE, disp_valid 0, disp_grant 0, disp_x 0, disp_y 0, busy 0, frame_done 0, arbiter pointer at core NUM_CORES-1 (core 0 first).
- start at edge N -> state DISPATCH at N+1; first possible disp_valid at N+2.
- req sampled at edge M -> disp_valid/grant/coordinates registered, visible after M+1; peak throughput one pixel per cycle with ≥2 requesting cores, one per two cycles with a single core.
- Last grant at edge L -> DRAIN at L+1; last core_done at edge D -> DONE at D+1, frame_done high D+1..D+2.
- All outputs registered; no combinational input-to-output path.

## Configuration
- PIX_DISPATCH_STATS_EN defined: adds output frame_cycles (32 bits), cleared on accepted start, increments every cycle busy=1, holds after frame_done until next start; reset 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package pix_dispatch_pkg: state enum type, state encodings, counter-width helper constant.
- One sub-module: rr_arbiter (parameter N; in req, advance; out one-hot grant, rotating pointer), instantiated once.

## Test plan
- Reset mid-DISPATCH (x=2,y=1) -> all outputs 0, state IDLE, next start restarts at (0,0).
- x_max=3,y_max=2, 4 cores always requesting -> 12 grants in order core0,1,2,3,0..., coordinates (0,0)..(3,2) raster, frame_done one cycle after last core_done.
- Single core req held, done 3 cycles after each grant -> grants every other cycle minimum, never double-granted, outstanding never exceeds 1.
- Cores 1 and 3 retire on same cycle as new grant to core 0 -> outstanding changes by −1 net.
- abort with 3 outstanding -> IDLE next cycle, no frame_done, subsequent core_done pulses ignored.
- x_max=0,y_max=0 -> exactly one grant (0,0), DRAIN, frame_done after its core_done; with PIX_DISPATCH_STATS_EN, frame_cycles equals busy-high cycle count.
